port_rd_scheduler: RTL and testbench

- Per-output-port read scheduler: one instance per port, 16 in total.
- Each cycle it picks which of the port's 8 priority queues is served next, using either strict priority or weighted round robin (WRR).
- It hands the pick to the port's read engine through a valid/ack handshake, then holds off further grants until that engine reports the end of the packet.
- It sits between the per-port queue head/tail bookkeeping (which supplies the queue-non-empty flags) and the read engine that drives rd_sop/rd_vld/rd_data/rd_eop.

---
 rtl/hydra_pkg.sv | 32 +++
 rtl/prior_rr_picker.sv | 29 ++
 rtl/port_rd_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_port_rd_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hydra_pkg.sv
// Shared types and constants for the per-port read scheduler.
package hydra_pkg;

    localparam int PRIOR_NUM = 8;
    localparam int WEIGHT_W  = 4;

    localparam logic [WEIGHT_W-1:0] CREDIT_ZERO = {WEIGHT_W{1'b0}};
    localparam logic [WEIGHT_W-1:0] CREDIT_ONE  = {{(WEIGHT_W-1){1'b0}}, 1'b1};

    typedef logic [2:0] prior_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } sched_state_e;

    // A programmed weight of zero still earns one grant per round.
    function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [WEIGHT_W-1:0] w);
        return (w == CREDIT_ZERO) ? CREDIT_ONE : w;
    endfunction

    // Bit-reverse a queue mask so a lowest-first scan finds the highest index.
    function automatic logic [PRIOR_NUM-1:0] reverse_mask(input logic [PRIOR_NUM-1:0] m);
        logic [PRIOR_NUM-1:0] r;
        for (int i = 0; i < PRIOR_NUM; i++) begin
            r[i] = m[PRIOR_NUM-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/prior_rr_picker.sv
// Circular first-set finder: starting at 'start' and wrapping 7 -> 0,
// returns the first requesting queue index.
module prior_rr_picker
    import hydra_pkg::*;
(
    input  logic [PRIOR_NUM-1:0] req,
    input  prior_t               start,
    output logic                 found,
    output prior_t               idx
);

    prior_t cand_s;
    logic   hit_s;

    // Scan outward from start; the first hit wins, later hits are masked by found.
    always_comb begin
        found  = 1'b0;
        idx    = 3'd0;
        cand_s = 3'd0;
        hit_s  = 1'b0;
        for (int k = 0; k < PRIOR_NUM; k++) begin
            cand_s = start + prior_t'(k);
            hit_s  = ~found & req[cand_s];
            idx    = hit_s ? cand_s : idx;
            found  = found | req[cand_s];
        end
    end

endmodule

// File: rtl/port_rd_scheduler.sv
// Per-output-port read scheduler: strict priority or WRR pick among 8 queues,
// grant via valid/ack, then hold off until the read engine reports packet end.
// Optional starvation aging in strict mode is compiled in with SCHED_AGING_EN.
module port_rd_scheduler
    import hydra_pkg::*;
`ifdef SCHED_AGING_EN
#(
    parameter logic [7:0] AGE_LIMIT = 8'd64
)
`endif
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wrr_enable,
    input  logic [PRIOR_NUM-1:0]          queue_nonempty,
    input  logic [PRIOR_NUM*WEIGHT_W-1:0] weight,
    input  logic                          ready,
    output logic                          sched_vld,
    output logic [2:0]                    sched_prior,
    input  logic                          sched_ack,
    input  logic                          pkt_done,
    output logic                          busy
);

    sched_state_e                         state_q, state_d;
    logic                                 sched_vld_q, sched_vld_d;
    prior_t                               sched_prior_q, sched_prior_d;
    logic                                 busy_q, busy_d;
    prior_t                               rr_ptr_q, rr_ptr_d;
    logic [PRIOR_NUM-1:0][WEIGHT_W-1:0]   credit_q, credit_d;
    // Mode in which the outstanding grant was issued (1 = WRR).
    logic                                 mode_q, mode_d;

    logic [PRIOR_NUM-1:0]                 has_credit_s;
    logic [PRIOR_NUM-1:0]                 wrr_req_s;
    logic                                 wrr_found_s;
    prior_t                               wrr_idx_s;
    logic [PRIOR_NUM-1:0]                 strict_req_s;
    logic                                 strict_found_s;
    prior_t                               strict_raw_s;
    prior_t                               strict_idx_s;

`ifdef SCHED_AGING_EN
    logic [7:0]                           age_q, age_d;
    // Set when the outstanding grant was the starvation pick.
    logic                                 aged_q, aged_d;
    logic                                 age_hit_s;
    logic                                 waiting_s;
`endif

    // Queues eligible for a WRR grant: non-empty and still holding credit.
    always_comb begin
        has_credit_s = {PRIOR_NUM{1'b0}};
        for (int i = 0; i < PRIOR_NUM; i++) begin
            has_credit_s[i] = (credit_q[i] != CREDIT_ZERO);
        end
        wrr_req_s = queue_nonempty & has_credit_s;
    end

`ifdef SCHED_AGING_EN
    // Strict request mask: reversed when starvation forces a highest-index pick.
    always_comb begin
        age_hit_s    = (age_q >= AGE_LIMIT);
        strict_req_s = age_hit_s ? reverse_mask(queue_nonempty) : queue_nonempty;
        strict_idx_s = age_hit_s ? (3'd7 - strict_raw_s) : strict_raw_s;
        waiting_s    = |(queue_nonempty & ~(PRIOR_NUM'(1) << sched_prior_q));
    end
`else
    // Strict request mask: plain lowest-index-first.
    always_comb begin
        strict_req_s = queue_nonempty;
        strict_idx_s = strict_raw_s;
    end
`endif

    prior_rr_picker u_wrr_pick (
        .req   (wrr_req_s),
        .start (rr_ptr_q),
        .found (wrr_found_s),
        .idx   (wrr_idx_s)
    );

    prior_rr_picker u_strict_pick (
        .req   (strict_req_s),
        .start (3'd0),
        .found (strict_found_s),
        .idx   (strict_raw_s)
    );

    // Next-state, grant, credit and pointer logic.
    always_comb begin
        state_d       = state_q;
        sched_vld_d   = sched_vld_q;
        sched_prior_d = sched_prior_q;
        rr_ptr_d      = rr_ptr_q;
        credit_d      = credit_q;
        mode_d        = mode_q;
`ifdef SCHED_AGING_EN
        age_d         = age_q;
        aged_d        = aged_q;
`endif
        case (state_q)
            IDLE: begin
                if (wrr_enable) begin
                    if (wrr_found_s) begin
                        if (ready) begin
                            sched_vld_d   = 1'b1;
                            sched_prior_d = wrr_idx_s;
                            mode_d        = 1'b1;
                            state_d       = GRANT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (|queue_nonempty) begin
                        // Round exhausted: refill all credits, grant next cycle.
                        for (int i = 0; i < PRIOR_NUM; i++) begin
                            credit_d[i] = eff_weight(weight[i*WEIGHT_W +: WEIGHT_W]);
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (strict_found_s && ready) begin
                        sched_vld_d   = 1'b1;
                        sched_prior_d = strict_idx_s;
                        mode_d        = 1'b0;
                        state_d       = GRANT;
`ifdef SCHED_AGING_EN
                        aged_d        = age_hit_s;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GRANT: begin
                if (sched_ack) begin
                    sched_vld_d = 1'b0;
                    state_d     = XFER;
                    if (mode_q) begin
                        credit_d[sched_prior_q] = credit_q[sched_prior_q] - CREDIT_ONE;
                        if (credit_q[sched_prior_q] == CREDIT_ONE) begin
                            rr_ptr_d = sched_prior_q + 3'd1;
                        end else begin
                            rr_ptr_d = sched_prior_q;
                        end
                    end else begin
`ifdef SCHED_AGING_EN
                        if (aged_q) begin
                            age_d = 8'd0;
                        end else if (waiting_s && (age_q != 8'hFF)) begin
                            age_d = age_q + 8'd1;
                        end else begin
                            age_d = age_q;
                        end
`else
                        credit_d = credit_q;
`endif
                    end
                end else begin
                    state_d = GRANT;
                end
            end
            XFER: begin
                if (pkt_done) begin
                    state_d = IDLE;
                end else begin
                    state_d = XFER;
                end
            end
            default: begin
                state_d     = IDLE;
                sched_vld_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            sched_vld_q   <= 1'b0;
            sched_prior_q <= 3'd0;
            busy_q        <= 1'b0;
            rr_ptr_q      <= 3'd0;
            credit_q      <= {(PRIOR_NUM*WEIGHT_W){1'b0}};
            mode_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sched_vld_q   <= sched_vld_d;
            sched_prior_q <= sched_prior_d;
            busy_q        <= busy_d;
            rr_ptr_q      <= rr_ptr_d;
            credit_q      <= credit_d;
            mode_q        <= mode_d;
        end
    end

`ifdef SCHED_AGING_EN
    // Starvation age counter and aged-grant marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age_q  <= 8'd0;
            aged_q <= 1'b0;
        end else begin
            age_q  <= age_d;
            aged_q <= aged_d;
        end
    end
`endif

    assign sched_vld   = sched_vld_q;
    assign sched_prior = sched_prior_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_port_rd_scheduler.sv
// Directed self-checking bench for port_rd_scheduler.
module tb_port_rd_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        wrr_enable;
    logic [7:0]  queue_nonempty;
    logic [31:0] weight;
    logic        ready;
    logic        sched_vld;
    logic [2:0]  sched_prior;
    logic        sched_ack;
    logic        pkt_done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifdef SCHED_AGING_EN
    port_rd_scheduler #(.AGE_LIMIT(8'd4)) dut (
`else
    port_rd_scheduler dut (
`endif
        .clk            (clk),
        .rst            (rst),
        .wrr_enable     (wrr_enable),
        .queue_nonempty (queue_nonempty),
        .weight         (weight),
        .ready          (ready),
        .sched_vld      (sched_vld),
        .sched_prior    (sched_prior),
        .sched_ack      (sched_ack),
        .pkt_done       (pkt_done),
        .busy           (busy)
    );

    task automatic apply_reset();
        rst            = 1'b1;
        wrr_enable     = 1'b0;
        queue_nonempty = 8'h00;
        weight         = 32'h0;
        ready          = 1'b0;
        sched_ack      = 1'b0;
        pkt_done       = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Cycles until sched_vld is seen at a negedge; -1 if the bound expires.
    task automatic wait_vld(input int maxc, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!sched_vld && cycles < maxc);
        if (!sched_vld) cycles = -1;
    endtask

    // Take one grant: ack for one cycle, pkt_done three cycles later.
    task automatic serve(output logic [2:0] p, output int lat);
        wait_vld(8, lat);
        p = sched_prior;
        if (lat < 0) return;
        sched_ack = 1'b1;
        @(negedge clk);
        sched_ack = 1'b0;
        repeat (2) @(negedge clk);
        pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (sched_vld !== 1'b0 || sched_prior !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got vld=%b prior=%0d busy=%b expected 0/0/0",
                     sched_vld, sched_prior, busy);
        end
        apply_reset();
        queue_nonempty = 8'h01;
        ready          = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sched_vld !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL not_ready_idle: got vld=%b busy=%b expected 0/0", sched_vld, busy);
        end
    endtask

    task automatic test_strict();
        logic [2:0] p;
        int lat;
        apply_reset();
        queue_nonempty = 8'b1010_0100;
        ready          = 1'b1;
        for (int i = 0; i < 3; i++) begin
            serve(p, lat);
            checks++;
            if (p !== 3'd2 || lat !== 1) begin
                errors++;
                $display("FAIL strict_prior[%0d]: got prior=%0d lat=%0d expected prior=2 lat=1", i, p, lat);
            end
        end
        queue_nonempty = 8'b1010_0000;
        serve(p, lat);
        checks++;
        if (p !== 3'd5 || lat !== 1) begin
            errors++;
            $display("FAIL strict_after_clear: got prior=%0d lat=%0d expected prior=5 lat=1", p, lat);
        end
    endtask

    task automatic test_wrr();
        logic [2:0] p;
        int lat;
        int exp_p [8];
        int exp_l [8];
        exp_p = '{0, 0, 1, 3, 0, 0, 1, 3};
        exp_l = '{2, 1, 1, 1, 2, 1, 1, 1};
        apply_reset();
        wrr_enable     = 1'b1;
        weight         = 32'h0000_0012;
        queue_nonempty = 8'b0000_1011;
        ready          = 1'b1;
        for (int i = 0; i < 8; i++) begin
            serve(p, lat);
            checks++;
            if (int'(p) !== exp_p[i] || lat !== exp_l[i]) begin
                errors++;
                $display("FAIL wrr_order[%0d]: got prior=%0d lat=%0d expected prior=%0d lat=%0d",
                         i, p, lat, exp_p[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_handshake_hold();
        int lat;
        apply_reset();
        queue_nonempty = 8'b0001_0000;
        ready          = 1'b1;
        wait_vld(8, lat);
        checks++;
        if (lat !== 1 || sched_prior !== 3'd4) begin
            errors++;
            $display("FAIL hold_grant: got lat=%0d prior=%0d expected lat=1 prior=4", lat, sched_prior);
        end
        queue_nonempty = 8'h00;
        for (int i = 0; i < 5; i++) begin
            ready = ~ready;
            @(negedge clk);
            checks++;
            if (sched_vld !== 1'b1 || sched_prior !== 3'd4) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got vld=%b prior=%0d expected vld=1 prior=4",
                         i, sched_vld, sched_prior);
            end
        end
        sched_ack = 1'b1;
        @(negedge clk);
        sched_ack = 1'b0;
        checks++;
        if (sched_vld !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_ack: got vld=%b busy=%b expected vld=0 busy=1", sched_vld, busy);
        end
        pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
        @(negedge clk);
        checks++;
        if (sched_vld !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle_empty: got vld=%b busy=%b expected 0/0", sched_vld, busy);
        end
    endtask

    task automatic test_done_timing();
        int lat;
        apply_reset();
        queue_nonempty = 8'b0000_1000;
        ready          = 1'b1;
        wait_vld(8, lat);
        pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
        checks++;
        if (lat !== 1 || sched_vld !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL done_in_grant: got lat=%0d vld=%b busy=%b expected lat=1 vld=1 busy=1",
                     lat, sched_vld, busy);
        end
        sched_ack = 1'b1;
        pkt_done  = 1'b1;
        @(negedge clk);
        sched_ack = 1'b0;
        pkt_done  = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (sched_vld !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL done_with_ack: got vld=%b busy=%b expected vld=0 busy=1", sched_vld, busy);
        end
        pkt_done = 1'b1;
        @(negedge clk);
        pkt_done = 1'b0;
        checks++;
        if (sched_vld !== 1'b0) begin
            errors++;
            $display("FAIL done_plus1: got vld=%b expected 0", sched_vld);
        end
        @(negedge clk);
        checks++;
        if (sched_vld !== 1'b1 || sched_prior !== 3'd3) begin
            errors++;
            $display("FAIL done_plus2: got vld=%b prior=%0d expected vld=1 prior=3", sched_vld, sched_prior);
        end
    endtask

    task automatic test_async_reset();
        logic [2:0] p;
        int lat;
        apply_reset();
        wrr_enable     = 1'b1;
        weight         = 32'h0000_0012;
        queue_nonempty = 8'b0000_1011;
        ready          = 1'b1;
        serve(p, lat);
        serve(p, lat);
        wait_vld(8, lat);
        sched_ack = 1'b1;
        @(negedge clk);
        sched_ack = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: got busy=%b expected 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (sched_vld !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: got vld=%b busy=%b expected 0/0", sched_vld, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_vld(8, lat);
        checks++;
        if (lat !== 2 || sched_prior !== 3'd0) begin
            errors++;
            $display("FAIL areset_first_grant: got lat=%0d prior=%0d expected lat=2 prior=0",
                     lat, sched_prior);
        end
    endtask

`ifdef SCHED_AGING_EN
    task automatic test_aging();
        logic [2:0] p;
        int lat;
        int exp_p [10];
        exp_p = '{0, 0, 0, 0, 7, 0, 0, 0, 0, 7};
        apply_reset();
        queue_nonempty = 8'b1000_0001;
        ready          = 1'b1;
        for (int i = 0; i < 10; i++) begin
            serve(p, lat);
            checks++;
            if (int'(p) !== exp_p[i] || lat !== 1) begin
                errors++;
                $display("FAIL aging[%0d]: got prior=%0d lat=%0d expected prior=%0d lat=1",
                         i, p, lat, exp_p[i]);
            end
        end
    endtask
`endif

    initial begin
        rst            = 1'b1;
        wrr_enable     = 1'b0;
        queue_nonempty = 8'h00;
        weight         = 32'h0;
        ready          = 1'b0;
        sched_ack      = 1'b0;
        pkt_done       = 1'b0;
        test_reset();
        test_strict();
        test_wrr();
        test_handshake_hold();
        test_done_timing();
        test_async_reset();
`ifdef SCHED_AGING_EN
        test_aging();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
